seq_detect_prog: RTL and testbench

Programmable serial bit-pattern detector: the parametrised successor of our fixed four-bit sequence detector. It watches a qualified serial bit stream and pulses `dout` whenever the most recent `len` bits equal a run-time-loaded pattern of up to `MAX_LEN` bits. It supports overlapping or non-overlapping matching and keeps a saturating match counter. It sits on a serial input path, behind whatever produces `din`/`din_valid`, and feeds control logic or status registers.

---
 rtl/seq_detect_prog_if.sv | 39 +++
 rtl/seq_detect_prog.sv | 144 ++++++++++++++
 tb/tb_seq_detect_prog.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_prog_if.sv
// rtl/seq_detect_prog_if.sv - stream/config/status bundle for the programmable sequence detector
//
// Groups every non-clock, non-reset signal of seq_detect_prog.
//   din, din_valid              serial bit and its qualifier
//   cfg_we, cfg_pattern,        configuration load strobe, pattern (bit 0 newest),
//   cfg_len, cfg_overlap        length (1..MAX_LEN) and overlap mode
//   cnt_clr                     synchronous match counter clear
//   dout                        one-cycle registered match pulse
//   match_count                 saturating match counter
//   cfg_err                     stored length is invalid
// master drives the inputs and observes status; slave is the detector.

interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               din;
    logic               din_valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               dout;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  dout, match_count, cfg_err
    );

    modport slave (
        input  din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output dout, match_count, cfg_err
    );
endinterface

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial bit-pattern detector with saturating match counter
//
// Pulses bus.dout for one cycle whenever the most recent len valid bits equal
// the low len bits of the stored pattern. Overlapping or non-overlapping
// matching is selected at configuration time.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    seq_detect_prog_if.slave (serial input, config load, counter clear,
//          dout / match_count / cfg_err status)

module seq_detect_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = 'b1010,
    parameter int                 DEF_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    seq_detect_prog_if.slave   bus
);

    localparam int               LEN_W     = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    function automatic logic len_ok(input logic [LEN_W-1:0] l);
        return (l != '0) && (l <= MAX_LEN_L);
    endfunction

    // State entered with an empty history: a one-bit pattern can match on
    // the very next valid bit, longer ones must collect len-1 bits first.
    function automatic state_t entry_state(input logic [LEN_W-1:0] l);
        if (!len_ok(l)) begin
            return IDLE;
        end else if (l == ONE_L) begin
            return RUN;
        end else begin
            return FILL;
        end
    endfunction

    // The oldest bit of a full-length match is still in hist while din
    // supplies the newest, so MAX_LEN-1 history bits are enough.
    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               match;

    always_comb begin
        window = {hist_q, bus.din};
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + ONE_L;
        // A config load owns the edge, so it suppresses any match.
        match = (state_q == RUN) && bus.din_valid && !bus.cfg_we &&
                (((window ^ pat_q) & mask) == '0);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        dout_d  = 1'b0;
        cnt_d   = cnt_q;

        if (bus.cfg_we) begin
            pat_d   = bus.cfg_pattern;
            len_d   = bus.cfg_len;
            ovl_d   = bus.cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = entry_state(bus.cfg_len);
        end else if (state_q != IDLE && bus.din_valid) begin
            if (match && !ovl_q) begin
                // Non-overlapping: the matched bits must not seed the next match.
                hist_d  = '0;
                fill_d  = '0;
                state_d = entry_state(len_q);
            end else begin
                hist_d  = window[MAX_LEN-2:0];
                fill_d  = fill_inc;
                state_d = (fill_inc >= len_q - ONE_L) ? RUN : FILL;
            end
        end

        dout_d = match;

        if (bus.cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= entry_state(DEF_LEN_L);
            pat_q   <= DEF_PAT;
            len_q   <= DEF_LEN_L;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.match_count = cnt_q;
    assign bus.cfg_err     = (state_q == IDLE);

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - scoreboard bench for seq_detect_prog

module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W),
        .DEF_PAT (8'b0000_1010),
        .DEF_LEN (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic dout;
        int   cnt;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    bit               mq[$];
    logic [7:0]       m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pat = 8'b0000_1010;
        m_len = 4;
        m_ovl = 1'b1;
        m_cnt = 0;
    endtask

    task automatic idle_inputs();
        bus.din         = 1'b0;
        bus.din_valid   = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cnt_clr     = 1'b0;
    endtask

    task automatic step(input string tag, input logic d, input logic v, input logic we,
                        input logic [7:0] p, input int l, input logic o, input logic clr);
        exp_t e;
        bit   match;
        int   n;
        @(negedge clk);
        bus.din         = d;
        bus.din_valid   = v;
        bus.cfg_we      = we;
        bus.cfg_pattern = p;
        bus.cfg_len     = LEN_W'(l);
        bus.cfg_overlap = o;
        bus.cnt_clr     = clr;

        match = 1'b0;
        if (we) begin
            m_pat = p;
            m_len = l;
            m_ovl = o;
            mq.delete();
        end else if (v && m_len >= 1 && m_len <= MAX_LEN) begin
            mq.push_back(d);
            if (mq.size() > MAX_LEN) void'(mq.pop_front());
            n = mq.size();
            if (n >= m_len) begin
                match = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (mq[n-1-k] != m_pat[k]) match = 1'b0;
                end
            end
            if (match && !m_ovl) mq.delete();
        end
        if (clr) m_cnt = match ? 1 : 0;
        else if (match && m_cnt < CNT_MAX) m_cnt++;

        e.dout = match;
        e.cnt  = m_cnt;
        e.err  = !(m_len >= 1 && m_len <= MAX_LEN);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_dout"}, int'(bus.dout), int'(e.dout));
        chk({tag, "_cnt"}, int'(bus.match_count), e.cnt);
        chk({tag, "_err"}, int'(bus.cfg_err), int'(e.err));
    endtask

    task automatic bit_in(input string tag, input logic d);
        step(tag, d, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic gap(input string tag, input logic d);
        step(tag, d, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    // din is driven valid during the load to show it is discarded.
    task automatic cfg(input string tag, input logic [7:0] p, input int l,
                       input logic o, input logic clr);
        step(tag, 1'b1, 1'b1, 1'b1, p, l, o, clr);
    endtask

    int want5[6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        idle_inputs();
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_cnt", int'(bus.match_count), 0);
        chk("rst_err", int'(bus.cfg_err), 0);
        @(negedge clk);
        reset = 1'b0;

        // Default 1010, overlapping.
        for (int i = 0; i < 6; i++) bit_in("t1", (i % 2) == 0);
        chk("t1_total", int'(bus.match_count), 2);

        // Non-overlapping.
        cfg("t2_cfg", 8'b0000_1010, 4, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) bit_in("t2", (i % 2) == 0);
        chk("t2_total", int'(bus.match_count), 2);

        // Gaps with toggling din are ignored.
        cfg("t3_cfg", 8'b0000_1010, 4, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in("t3", (i % 2) == 0);
            gap("t3_gap", (i % 2) != 0);
            gap("t3_gap", (i % 2) == 0);
        end
        chk("t3_total", int'(bus.match_count), 1);

        // 111 overlapping, then invalid lengths.
        cfg("t4_cfg", 8'b0000_0111, 3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) bit_in("t4", 1'b1);
        chk("t4_total", int'(bus.match_count), 3);
        cfg("t4_len0", 8'b0000_0111, 0, 1'b1, 1'b1);
        chk("t4_err0", int'(bus.cfg_err), 1);
        for (int i = 0; i < 6; i++) bit_in("t4_idle", (i % 3) != 0);
        cfg("t4_len9", 8'hFF, 9, 1'b1, 1'b0);
        chk("t4_err9", int'(bus.cfg_err), 1);
        for (int i = 0; i < 4; i++) bit_in("t4_idle9", 1'b1);
        chk("t4_idle_cnt", int'(bus.match_count), 0);

        // Single-bit pattern, counter saturation, clear coinciding with a match.
        cfg("t5_cfg", 8'b0000_0001, 1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bit_in("t5", 1'b1);
            chk("t5_seq", int'(bus.match_count), want5[i]);
        end
        step("t5_clr", 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        chk("t5_clr_cnt", int'(bus.match_count), 1);

        // Asynchronous reset mid-stream.
        cfg("t6_cfg", 8'b0000_1010, 4, 1'b0, 1'b0);
        bit_in("t6", 1'b1);
        bit_in("t6", 1'b0);
        bit_in("t6", 1'b1);
        #3;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_dout", int'(bus.dout), 0);
        chk("t6_rst_cnt", int'(bus.match_count), 0);
        chk("t6_rst_err", int'(bus.cfg_err), 0);
        @(negedge clk);
        reset = 1'b0;
        bit_in("t6_after", 1'b0);
        for (int i = 0; i < 6; i++) bit_in("t6_fresh", (i % 2) == 0);
        chk("t6_total", int'(bus.match_count), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
